// File: rtl/bip_control_unit.sv
// Control unit for the accumulator core: program counter, instruction decode, run/halt sequencing.
// Define BIP_CYCLE_COUNT_EN to build the saturating RUN-cycle counter; otherwise cycle_count is 0.
module bip_control_unit #(
    parameter int unsigned OPCODE_WIDTH  = 5,
    parameter int unsigned OPERAND_WIDTH = 11,
    parameter int unsigned PC_WIDTH      = 11,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr,
    input  logic                                  tx_done,
    output logic [PC_WIDTH-1:0]                   pc,
    output logic [OPERAND_WIDTH-1:0]              operand,
    output logic [1:0]                            SelA,
    output logic                                  SelB,
    output logic                                  Op,
    output logic                                  WrAcc,
    output logic                                  WrRam,
    output logic                                  RdRam,
    output logic                                  wr_uart,
    output logic                                  halted,
    output logic                                  illegal,
    output logic [CNT_WIDTH-1:0]                  cycle_count
);

    typedef enum logic [2:0] {StIdle, StRun, StHaltReq, StHaltWait, StHalted} stateT;

    localparam logic [OPCODE_WIDTH-1:0] OpHlt  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OpSto  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OpLd   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OpLdi  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OpAdd  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OpAddi = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OpSub  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OpSubi = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OpJmp  = OPCODE_WIDTH'(8);

    stateT                   stateQ, stateD;
    logic [PC_WIDTH-1:0]     pcQ, pcD;
    logic                    illegalQ, illegalD;
    logic [OPCODE_WIDTH-1:0] opcode;

    assign opcode  = instr[OPCODE_WIDTH+OPERAND_WIDTH-1 -: OPCODE_WIDTH];
    assign operand = instr[OPERAND_WIDTH-1:0];
    assign pc      = pcQ;
    assign illegal = illegalQ;
    assign wr_uart = (stateQ == StHaltReq);
    assign halted  = (stateQ == StHalted);

    always_comb begin
        stateD   = stateQ;
        pcD      = pcQ;
        illegalD = illegalQ;
        SelA     = 2'd0;
        SelB     = 1'b0;
        Op       = 1'b0;
        WrAcc    = 1'b0;
        WrRam    = 1'b0;
        RdRam    = 1'b0;
        case (stateQ)
            StIdle, StHalted: begin
                if (start) begin
                    stateD   = StRun;
                    pcD      = '0;
                    illegalD = 1'b0;
                end
            end
            StRun: begin
                pcD = pcQ + PC_WIDTH'(1);
                case (opcode)
                    OpHlt: begin
                        pcD    = pcQ;
                        stateD = StHaltReq;
                    end
                    OpSto: WrRam = 1'b1;
                    OpLd: begin
                        RdRam = 1'b1;
                        WrAcc = 1'b1;
                    end
                    OpLdi: begin
                        WrAcc = 1'b1;
                        SelA  = 2'd1;
                    end
                    OpAdd, OpSub: begin
                        RdRam = 1'b1;
                        WrAcc = 1'b1;
                        SelA  = 2'd2;
                        Op    = (opcode == OpAdd);
                    end
                    OpAddi, OpSubi: begin
                        WrAcc = 1'b1;
                        SelA  = 2'd2;
                        SelB  = 1'b1;
                        Op    = (opcode == OpAddi);
                    end
                    OpJmp: pcD = operand[PC_WIDTH-1:0];
                    default: begin
                        pcD      = pcQ;
                        illegalD = 1'b1;
                        stateD   = StHaltReq;
                    end
                endcase
            end
            StHaltReq:  stateD = StHaltWait;
            StHaltWait: if (tx_done) stateD = StHalted;
            default:    stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            pcQ      <= '0;
            illegalQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            pcQ      <= pcD;
            illegalQ <= illegalD;
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0] cntQ, cntD;
    logic                 restart;

    assign restart = start && ((stateQ == StIdle) || (stateQ == StHalted));

    // Counts every RUN cycle, including the one that halts; sticks at all-ones.
    always_comb begin
        cntD = cntQ;
        if (restart) begin
            cntD = '0;
        end else if ((stateQ == StRun) && (cntQ != '1)) begin
            cntD = cntQ + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign cycle_count = cntQ;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: directed scenarios and random forward-jump programs, each checked
// cycle by cycle against an instruction-level model that walks the same program memory.
`timescale 1ns/1ps
module tb_bip_control_unit;
    localparam int PW    = 11;
    localparam int CW    = 16;
    localparam int MaxPc = (1 << PW) - 1;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              start   = 1'b0;
    logic              tx_done = 1'b0;
    logic [15:0]       instr;
    logic [PW-1:0]     pc;
    logic [10:0]       operand;
    logic [1:0]        SelA;
    logic              SelB, Op, WrAcc, WrRam, RdRam, wr_uart, halted, illegal;
    logic [CW-1:0]     cycle_count;
    logic [6:0]        ctl;
    logic [15:0]       prog [0:MaxPc];

    int  nCmp = 0;
    int  nErr = 0;
    int  mPc, mCnt;
    bit  mIll;
    bit  wrapPatch = 1'b0;

    always #5 clk = ~clk;

    assign instr = prog[pc];
    assign ctl   = {SelA, SelB, Op, WrAcc, WrRam, RdRam};

    bip_control_unit #(
        .OPCODE_WIDTH (5),
        .OPERAND_WIDTH(11),
        .PC_WIDTH     (PW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr      (instr),
        .tx_done    (tx_done),
        .pc         (pc),
        .operand    (operand),
        .SelA       (SelA),
        .SelB       (SelB),
        .Op         (Op),
        .WrAcc      (WrAcc),
        .WrRam      (WrRam),
        .RdRam      (RdRam),
        .wr_uart    (wr_uart),
        .halted     (halted),
        .illegal    (illegal),
        .cycle_count(cycle_count)
    );

    function automatic logic [15:0] mk(input int op, input int arg);
        logic [4:0]  o;
        logic [10:0] a;
        o = op[4:0];
        a = arg[10:0];
        return {o, a};
    endfunction

    // {SelA, SelB, Op, WrAcc, WrRam, RdRam} expected for an opcode executing in RUN.
    function automatic logic [6:0] expCtl(input int op);
        case (op)
            1:       return 7'b00_0_0_0_1_0;
            2:       return 7'b00_0_0_1_0_1;
            3:       return 7'b01_0_0_1_0_0;
            4:       return 7'b10_0_1_1_0_1;
            5:       return 7'b10_1_1_1_0_0;
            6:       return 7'b10_0_0_1_0_1;
            7:       return 7'b10_1_0_1_0_0;
            default: return 7'b00_0_0_0_0_0;
        endcase
    endfunction

    function automatic int expCount(input int n);
`ifdef BIP_CYCLE_COUNT_EN
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag, input int expPc, input bit expIll);
        check({tag, "_pc"}, 32'(pc), 32'(expPc));
        check({tag, "_ctl"}, 32'(ctl), 32'd0);
        check({tag, "_uart"}, 32'(wr_uart), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'(expIll));
    endtask

    // Called just after a negedge; the following posedge samples start.
    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered in the first RUN cycle; returns in the first HALTED cycle.
    task automatic runProgram(input int txDelay, input bit noisy);
        int op;
        int steps;
        bit done;
        steps = 0;
        done  = 1'b0;
        mPc   = 0;
        mCnt  = 0;
        mIll  = 1'b0;
        while (!done) begin
            op = int'(prog[mPc][15:11]);
            check("run_pc", 32'(pc), 32'(mPc));
            check("run_ctl", 32'(ctl), 32'(expCtl(op)));
            check("run_operand", 32'(operand), 32'(prog[mPc][10:0]));
            check("run_flags", 32'({wr_uart, halted, illegal}), 32'd0);
            check("run_count", 32'(cycle_count), 32'(expCount(mCnt)));
            tx_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            start   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            mCnt++;
            if (op == 0 || op > 8) begin
                done = 1'b1;
                mIll = (op > 8);
            end else if (op == 8) begin
                mPc = int'(prog[mPc][PW-1:0]);
            end else begin
                if (wrapPatch && mPc == MaxPc) prog[0] = mk(0, 0);
                mPc = (mPc + 1) % (MaxPc + 1);
            end
            steps++;
            if (!done && steps > 200) begin
                check("run_budget", 32'(steps), 32'd200);
                done = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("req_uart", 32'(wr_uart), 32'd1);
        check("req_pc", 32'(pc), 32'(mPc));
        check("req_ctl", 32'(ctl), 32'd0);
        check("req_illegal", 32'(illegal), 32'(mIll));
        check("req_halted", 32'(halted), 32'd0);
        check("req_count", 32'(cycle_count), 32'(expCount(mCnt)));
        tx_done = 1'b1;  // lands in the request cycle and must not release the wait
        @(negedge clk);
        tx_done = 1'b0;
        for (int i = 0; i <= txDelay; i++) begin
            check("wait_halted", 32'(halted), 32'd0);
            checkQuiet("wait", mPc, mIll);
            if (i == txDelay) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        check("done_halted", 32'(halted), 32'd1);
        checkQuiet("done", mPc, mIll);
        check("done_count", 32'(cycle_count), 32'(expCount(mCnt)));
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_count"}, 32'(cycle_count), 32'd0);
        checkQuiet(tag, 0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a <= MaxPc; a++) prog[a] = mk(3, 0);

        // Reset held across a clock edge.
        @(negedge clk);
        checkReset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkReset("idle");

        // Basic program: LDI 5, ADDI 3, STO 10, HLT; tx_done five cycles after the request.
        prog[0] = mk(3, 5);
        prog[1] = mk(5, 3);
        prog[2] = mk(1, 10);
        prog[3] = mk(0, 0);
        pulseStart();
        runProgram(4, 1'b0);
        check("basic_count", 32'(cycle_count), 32'(expCount(4)));
        @(negedge clk);
        check("basic_hold_pc", 32'(pc), 32'd3);
        check("basic_hold_halted", 32'(halted), 32'd1);

        // Jumps and PC wrap: JMP 7 at pc 2, then JMP to the last address and fall through to 0.
        prog[0]     = mk(3, 1);
        prog[1]     = mk(4, 2);
        prog[2]     = mk(8, 7);
        prog[7]     = mk(7, 1);
        prog[8]     = mk(8, MaxPc);
        prog[MaxPc] = mk(5, 4);
        wrapPatch   = 1'b1;
        pulseStart();
        runProgram($urandom_range(0, 3), 1'b1);
        wrapPatch   = 1'b0;
        check("wrap_final_pc", 32'(pc), 32'd0);

        // Illegal opcode at pc 4.
        prog[0] = mk(3, 9);
        prog[1] = mk(4, 1);
        prog[2] = mk(1, 2);
        prog[3] = mk(7, 3);
        prog[4] = mk(31, 16'h5a);
        pulseStart();
        runProgram(2, 1'b1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_pc", 32'(pc), 32'd4);

        // Restart from HALTED clears illegal.
        prog[0] = mk(6, 1);
        prog[1] = mk(2, 3);
        prog[2] = mk(0, 0);
        pulseStart();
        runProgram(0, 1'b1);

        // Reset while waiting for the UART: illegal set at pc 2, then aborted.
        prog[0] = mk(3, 1);
        prog[1] = mk(3, 2);
        prog[2] = mk(20, 0);
        pulseStart();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_illegal", 32'(illegal), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("rst_wait");
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        rst_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkReset("post_rst_wait");
        end

        // Reset mid-RUN.
        prog[0] = mk(3, 1);
        prog[1] = mk(4, 2);
        prog[2] = mk(5, 3);
        prog[3] = mk(0, 0);
        pulseStart();
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_pc", 32'(pc), 32'd2);
        rst_n = 1'b0;
        #1;
        checkReset("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkReset("post_rst_run");
        end

        // Random forward-jump programs over addresses 0..15, always ending in a halt.
        for (int k = 0; k < 10; k++) begin
            for (int a = 0; a < 16; a++) begin
                int op;
                if (a == 15 || $urandom_range(0, 7) == 0) begin
                    op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 31));
                    prog[a] = mk(op, int'($urandom_range(0, MaxPc)));
                end else begin
                    op = int'($urandom_range(1, 8));
                    if (op == 8) prog[a] = mk(8, int'($urandom_range(a + 1, 15)));
                    else         prog[a] = mk(op, int'($urandom_range(0, MaxPc)));
                end
            end
            pulseStart();
            runProgram(int'($urandom_range(0, 5)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
